// File: rtl/booth_mac_pipe.sv
// booth_mac_pipe: 3-stage signed multiply-accumulate pipeline with a radix-4 Booth multiplier.
//   S1 registers the Booth partial products.
//   S2 registers the carry-save reduced, carry-propagate added product.
//   S3 registers the accumulate/pass result, the accumulator and the sticky overflow flag.
// A single valid/ready handshake governs the whole pipe. A held output freezes every stage.
// Optional feature: define BOOTH_MAC_SAT_EN to saturate overflowing accumulates.
// Without it, overflowing accumulates wrap modulo 2^ACC_WIDTH.
// Overflow is flagged in both modes.
module booth_mac_pipe #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 acc_en,
    input  logic                 clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 overflow
);

    localparam int unsigned NPP = WIDTH / 2;   // number of Booth partial products
    localparam int unsigned PPW = WIDTH + 2;   // partial product width (covers +/-2a)
    localparam int unsigned PW  = 2 * WIDTH;   // exact product width

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Each partial product's sign bit is inverted so that rows can be added as unsigned values.
    // This constant subtracts the 2^(PPW-1) bias that the inversion adds at each row's weight.
    function automatic logic [PW-1:0] sign_const();
        logic [PW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NPP; i++) begin
            c = c - (PW'(1) << (PPW - 1 + 2 * i));
        end
        return c;
    endfunction

    localparam logic [PW-1:0] SIGN_CONST = sign_const();

    // Pipeline-wide stall: the held output blocks every stage.
    logic stall;

    // S1 state
    logic                     s1_valid_q,  s1_valid_d;
    logic                     s1_acc_en_q, s1_acc_en_d;
    logic                     s1_clr_q,    s1_clr_d;
    logic [NPP-1:0][PPW-1:0]  pp_q,        pp_d;

    // S2 state
    logic                     s2_valid_q,  s2_valid_d;
    logic                     s2_acc_en_q, s2_acc_en_d;
    logic                     s2_clr_q,    s2_clr_d;
    logic [PW-1:0]            prod_q,      prod_d;

    // S3 state
    logic                     s3_valid_q,  s3_valid_d;
    logic [ACC_WIDTH-1:0]     acc_q,       acc_d;
    logic [ACC_WIDTH-1:0]     result_q,    result_d;
    logic                     ovf_q,       ovf_d;

    assign stall     = s3_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = s3_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;

    // S1: radix-4 Booth recoding of b; each digit selects 0, +/-a or +/-2a.
    always_comb begin
        logic [WIDTH:0]   b_ext;
        logic [PPW-1:0]   a1;
        logic [PPW-1:0]   a2;
        logic [2:0]       trip;
        s1_valid_d  = s1_valid_q;
        s1_acc_en_d = s1_acc_en_q;
        s1_clr_d    = s1_clr_q;
        pp_d        = pp_q;
        b_ext       = {b, 1'b0};
        a1          = PPW'(signed'(a));
        a2          = a1 << 1;
        trip        = '0;
        if (!stall) begin
            s1_valid_d  = in_valid;
            s1_acc_en_d = acc_en;
            s1_clr_d    = clr;
            for (int unsigned i = 0; i < NPP; i++) begin
                trip = b_ext[2*i +: 3];
                case (trip)
                    3'b001, 3'b010: pp_d[i] = a1;
                    3'b011:         pp_d[i] = a2;
                    3'b100:         pp_d[i] = -a2;
                    3'b101, 3'b110: pp_d[i] = -a1;
                    default:        pp_d[i] = '0;
                endcase
            end
        end
    end

    // S2: carry-save reduction of the biased partial-product rows, then one carry-propagate add.
    always_comb begin
        logic [PW-1:0] sum;
        logic [PW-1:0] carry;
        logic [PW-1:0] row;
        logic [PW-1:0] maj;
        s2_valid_d  = s2_valid_q;
        s2_acc_en_d = s2_acc_en_q;
        s2_clr_d    = s2_clr_q;
        prod_d      = prod_q;
        sum         = SIGN_CONST;
        carry       = '0;
        row         = '0;
        maj         = '0;
        // Carry bits shifted out past PW only drop multiples of 2^PW, so the product stays exact.
        for (int unsigned i = 0; i < NPP; i++) begin
            row   = PW'({~pp_q[i][PPW-1], pp_q[i][PPW-2:0]}) << (2 * i);
            maj   = (sum & carry) | (sum & row) | (carry & row);
            sum   = sum ^ carry ^ row;
            carry = maj << 1;
        end
        if (!stall) begin
            s2_valid_d  = s1_valid_q;
            s2_acc_en_d = s1_acc_en_q;
            s2_clr_d    = s1_clr_q;
            prod_d      = sum + carry;
        end
    end

    // S3: accumulate or pass the product through, and track sticky signed overflow.
    always_comb begin
        logic [ACC_WIDTH-1:0] prod_ext;
        logic [ACC_WIDTH-1:0] acc_base;
        logic [ACC_WIDTH-1:0] acc_sum;
        logic [ACC_WIDTH-1:0] acc_next;
        logic                 add_ovf;
        logic                 ovf_base;
        s3_valid_d = s3_valid_q;
        acc_d      = acc_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        prod_ext   = ACC_WIDTH'(signed'(prod_q));
        acc_base   = s2_clr_q ? '0 : acc_q;
        ovf_base   = s2_clr_q ? 1'b0 : ovf_q;
        acc_sum    = acc_base + prod_ext;
        add_ovf    = (acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                     (acc_sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
`ifdef BOOTH_MAC_SAT_EN
        if (add_ovf) begin
            acc_next = acc_base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = acc_sum;
        end
`else
        acc_next   = acc_sum;
`endif
        if (!stall) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                if (s2_acc_en_q) begin
                    acc_d    = acc_next;
                    result_d = acc_next;
                    ovf_d    = ovf_base | add_ovf;
                end else begin
                    acc_d    = acc_base;
                    result_d = prod_ext;
                    ovf_d    = ovf_base;
                end
            end
        end
    end

    // All pipeline registers; reset discards in-flight beats and clears the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_acc_en_q <= 1'b0;
            s1_clr_q    <= 1'b0;
            pp_q        <= '0;
            s2_valid_q  <= 1'b0;
            s2_acc_en_q <= 1'b0;
            s2_clr_q    <= 1'b0;
            prod_q      <= '0;
            s3_valid_q  <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_acc_en_q <= s1_acc_en_d;
            s1_clr_q    <= s1_clr_d;
            pp_q        <= pp_d;
            s2_valid_q  <= s2_valid_d;
            s2_acc_en_q <= s2_acc_en_d;
            s2_clr_q    <= s2_clr_d;
            prod_q      <= prod_d;
            s3_valid_q  <= s3_valid_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
